// File: rtl/mem_burst_reader_if.sv
// Bus bundle for mem_burst_reader: burst command, memory read port and output stream.
// The slave modport is the reader itself; master is the surrounding system.
interface mem_burst_reader_if #(
  parameter int unsigned DATAW = 8,
  parameter int unsigned ADDRW = 9,
  parameter int unsigned LENW  = 10
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [ADDRW-1:0] cmd_base;
  logic [LENW-1:0]  cmd_len;
  logic [ADDRW-1:0] mem_raddr;
  logic [DATAW-1:0] mem_rdata;
  logic             out_valid;
  logic             out_ready;
  logic [DATAW-1:0] out_data;
  logic             out_last;

  modport master (
    output cmd_valid, cmd_base, cmd_len, mem_rdata, out_ready,
    input  cmd_ready, mem_raddr, out_valid, out_data, out_last
  );

  modport slave (
    input  cmd_valid, cmd_base, cmd_len, mem_rdata, out_ready,
    output cmd_ready, mem_raddr, out_valid, out_data, out_last
  );
endinterface

// File: rtl/mem_burst_reader.sv
// Burst read sequencer for a 2-cycle-latency memory: issues one read per cycle under
// credit control and re-times returned words into a valid/ready stream with a last flag.
module mem_burst_reader #(
  parameter int unsigned DATAW      = 8,
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned ADDRW      = $clog2(DEPTH),
  parameter int unsigned LENW       = ADDRW + 1,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned OBUF_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  mem_burst_reader_if.slave  bus,
  output logic               busy,
  output logic               done
);

  localparam int unsigned PTRW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam int unsigned CNTW = $clog2(OBUF_DEPTH + RD_LATENCY + 1) + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e state_q, state_d;

  logic [ADDRW-1:0]      raddr_q;
  logic [LENW-1:0]       remaining_q;
  logic [RD_LATENCY-1:0] sr_valid_q, sr_last_q;
  logic [DATAW-1:0]      buf_data_q [OBUF_DEPTH];
  logic [OBUF_DEPTH-1:0] buf_last_q;
  logic [PTRW-1:0]       rd_ptr_q, wr_ptr_q;
  logic [CNTW-1:0]       occ_q, inflight;
  logic                  done_q;

  logic accept, accept_go, accept_zero, issue, last_issue, push, pop, burst_end;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(OBUF_DEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CNTW'(sr_valid_q[i]);
    end
  end

  assign accept      = bus.cmd_valid && bus.cmd_ready;
  assign accept_go   = accept && (bus.cmd_len != '0);
  assign accept_zero = accept && (bus.cmd_len == '0);
  assign last_issue  = issue && (remaining_q == LENW'(1));
  assign push        = sr_valid_q[RD_LATENCY-1];
  assign pop         = bus.out_valid && bus.out_ready;
  // Last beat leaving the buffer with nothing still in flight ends the burst.
  assign burst_end   = (state_q == StDrain) && pop && bus.out_last && (inflight == '0);

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept_go)  state_d = StIssue;
      StIssue: if (last_issue) state_d = StDrain;
      StDrain: if (burst_end)  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs. Credits cover buffered plus in-flight words; a same-cycle pop is not counted.
  always_comb begin
    bus.cmd_ready = (state_q == StIdle);
    busy          = (state_q != StIdle);
    issue         = (state_q == StIssue) && ((occ_q + inflight) < CNTW'(OBUF_DEPTH));
    bus.mem_raddr = raddr_q;
    bus.out_valid = (occ_q != '0);
    bus.out_data  = buf_data_q[rd_ptr_q];
    bus.out_last  = buf_last_q[rd_ptr_q];
    done          = done_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      raddr_q     <= '0;
      remaining_q <= '0;
      sr_valid_q  <= '0;
      sr_last_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      if (accept_go) begin
        raddr_q     <= bus.cmd_base;
        remaining_q <= bus.cmd_len;
      end else if (issue) begin
        raddr_q     <= (raddr_q == ADDRW'(DEPTH - 1)) ? '0 : raddr_q + ADDRW'(1);
        remaining_q <= remaining_q - LENW'(1);
      end
      sr_valid_q <= (sr_valid_q << 1) | RD_LATENCY'(issue);
      sr_last_q  <= (sr_last_q << 1) | RD_LATENCY'(last_issue);
      done_q     <= accept_zero || burst_end;
    end
  end

  // Output buffer (peek FIFO)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < OBUF_DEPTH; i++) buf_data_q[i] <= '0;
      buf_last_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      occ_q      <= '0;
    end else begin
      if (push) begin
        buf_data_q[wr_ptr_q] <= bus.mem_rdata;
        buf_last_q[wr_ptr_q] <= sr_last_q[RD_LATENCY-1];
        wr_ptr_q             <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop)      occ_q <= occ_q + CNTW'(1);
      else if (!push && pop) occ_q <= occ_q - CNTW'(1);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && (occ_q == CNTW'(OBUF_DEPTH))));

endmodule

// File: tb/tb_mem_burst_reader.sv
// Self-checking bench for mem_burst_reader: table of bursts plus hand-timed corner cases,
// with a queue scoreboard fed when commands are driven and drained at each accepted beat.
module tb_mem_burst_reader;
  localparam int unsigned DATAW = 8;
  localparam int unsigned DEPTH = 512;
  localparam int unsigned ADDRW = 9;
  localparam int unsigned LENW  = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy, done;

  always #5 clk = ~clk;

  mem_burst_reader_if #(.DATAW(DATAW), .ADDRW(ADDRW), .LENW(LENW)) bus ();

  mem_burst_reader #(.DATAW(DATAW), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy),
    .done (done)
  );

  // Memory model: registered address then registered data
  logic [DATAW-1:0] mem [DEPTH];
  logic [ADDRW-1:0] mem_addr_q;
  logic [DATAW-1:0] mem_data_q;
  initial for (int i = 0; i < DEPTH; i++) mem[i] = DATAW'(i);
  always @(posedge clk) begin
    mem_addr_q <= bus.mem_raddr;
    mem_data_q <= mem[mem_addr_q];
  end
  assign bus.mem_rdata = mem_data_q;

  typedef struct packed {
    logic [DATAW-1:0] data;
    logic             last;
  } beat_t;

  typedef struct {
    int base;
    int len;
    int pct;
    int exp_beats;
    int exp_final;
  } vec_t;

  beat_t            exp_q[$];
  int               checks = 0;
  int               errors = 0;
  int               beat_cnt = 0;
  int               last_cnt = 0;
  logic [DATAW-1:0] last_data = '0;
  int               pops_total = 0;
  int               issued = 0;
  int               max_out = 0;
  logic [ADDRW-1:0] prev_raddr = '0;
  logic             prev_busy = 1'b0;
  int               ready_pct = 100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    bus.out_ready = ($urandom_range(99) < ready_pct);
  end

  // Monitor: issues inferred from address advances while busy, beats scored on handshake
  always @(negedge clk) begin
    if (rst) begin
      if (busy && prev_busy && (bus.mem_raddr != prev_raddr)) issued++;
      if (issued - pops_total > max_out) max_out = issued - pops_total;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected no beat", bus.out_data);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data", 32'(bus.out_data), 32'(e.data));
          check("beat_last", 32'(bus.out_last), 32'(e.last));
        end
        beat_cnt++;
        if (bus.out_last) begin
          last_cnt++;
          last_data = bus.out_data;
        end
        pops_total++;
      end
    end
    prev_raddr = bus.mem_raddr;
    prev_busy  = busy;
  end

  task automatic send_cmd(input int base, input int len);
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b.data = DATAW'((base + i) % DEPTH);
      b.last = (i == len - 1);
      exp_q.push_back(b);
    end
    @(posedge clk);
    #2;
    check("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_base  = ADDRW'(base);
    bus.cmd_len   = LENW'(len);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("done_seen", 32'(done), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    check({tag, "_raddr"}, 32'(bus.mem_raddr), 32'd0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
    check({tag, "_out_last"}, 32'(bus.out_last), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    vec_t vecs[6];
    int   p0;
    int   n;
    vecs[0] = '{10, 4, 100, 4, 13};
    vecs[1] = '{510, 4, 100, 4, 1};
    vecs[2] = '{0, 0, 100, 0, 0};
    vecs[3] = '{0, 512, 50, 512, 255};
    vecs[4] = '{5, 7, 30, 7, 11};
    vecs[5] = '{200, 3, 70, 3, 202};

    bus.cmd_valid = 1'b0;
    bus.cmd_base  = '0;
    bus.cmd_len   = '0;
    bus.out_ready = 1'b1;
    #12;
    check_reset_values("reset");
    #11;
    rst = 1'b1;

    // Exact timing: base 10, len 4, always ready
    beat_cnt = 0;
    send_cmd(10, 4);
    check("t_raddr_e0", 32'(bus.mem_raddr), 32'd10);
    check("t_busy_e0", 32'(busy), 32'd1);
    check("t_cmd_ready_e0", 32'(bus.cmd_ready), 32'd0);
    check("t_out_valid_e0", 32'(bus.out_valid), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (k <= 3) check("t_raddr", 32'(bus.mem_raddr), 32'(10 + k));
      check("t_out_valid", 32'(bus.out_valid), 32'(k >= 3));
      if (k >= 3) begin
        check("t_out_data", 32'(bus.out_data), 32'(10 + k - 3));
        check("t_out_last", 32'(bus.out_last), 32'(k == 6));
      end
    end
    @(posedge clk);
    #1;
    check("t_done_pulse", 32'(done), 32'd1);
    check("t_cmd_ready_done", 32'(bus.cmd_ready), 32'd1);
    check("t_busy_done", 32'(busy), 32'd0);
    check("t_out_valid_done", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("t_done_one_cycle", 32'(done), 32'd0);
    check("t_beats", 32'(beat_cnt), 32'd4);

    // Backpressure: only four reads may be outstanding
    ready_pct = 100;
    ready_pct = 0;
    repeat (2) @(posedge clk);
    beat_cnt = 0;
    last_cnt = 0;
    send_cmd(0, 8);
    repeat (10) @(posedge clk);
    #1;
    check("bp_raddr_hold", 32'(bus.mem_raddr), 32'd4);
    check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    check("bp_out_data", 32'(bus.out_data), 32'd0);
    check("bp_outstanding", 32'(issued - pops_total), 32'd4);
    repeat (3) @(posedge clk);
    #1;
    check("bp_raddr_still", 32'(bus.mem_raddr), 32'd4);
    ready_pct = 100;
    wait_done(100);
    check("bp_beats", 32'(beat_cnt), 32'd8);
    check("bp_last_cnt", 32'(last_cnt), 32'd1);
    check("bp_last_data", 32'(last_data), 32'd7);

    // Zero length: done exactly one cycle after accept, no beats
    beat_cnt = 0;
    send_cmd(0, 0);
    check("z_done", 32'(done), 32'd1);
    check("z_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check("z_done_gone", 32'(done), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("z_no_beats", 32'(beat_cnt), 32'd0);
    check("z_out_valid", 32'(bus.out_valid), 32'd0);

    // Table of bursts
    for (int v = 0; v < 6; v++) begin
      ready_pct = vecs[v].pct;
      @(posedge clk);
      beat_cnt = 0;
      last_cnt = 0;
      send_cmd(vecs[v].base, vecs[v].len);
      wait_done(5000);
      check("vec_queue_empty", 32'(exp_q.size()), 32'd0);
      check("vec_beats", 32'(beat_cnt), 32'(vecs[v].exp_beats));
      check("vec_last_cnt", 32'(last_cnt), 32'(vecs[v].exp_beats > 0));
      if (vecs[v].exp_beats > 0) check("vec_last_data", 32'(last_data), 32'(vecs[v].exp_final));
      check("vec_busy_after", 32'(busy), 32'd0);
    end
    check("max_outstanding_le_4", 32'(max_out <= 4), 32'd1);

    // Async reset mid-burst after two beats have been popped
    ready_pct = 100;
    @(posedge clk);
    p0 = pops_total;
    n = 0;
    send_cmd(0, 8);
    while (pops_total - p0 < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("r_two_pops", 32'(pops_total - p0 >= 2), 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    exp_q.delete();
    issued = 0;
    pops_total = 0;
    #1;
    check_reset_values("midrst");
    repeat (3) @(posedge clk);
    #4;
    rst = 1'b1;
    beat_cnt = 0;
    last_cnt = 0;
    send_cmd(100, 2);
    wait_done(100);
    check("r_beats", 32'(beat_cnt), 32'd2);
    check("r_last_data", 32'(last_data), 32'd101);
    check("r_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_burst_reader.md
Name: mem_burst_reader

Overview:
- Read-side sequencer for the dual-port memory block (registered read address and registered read data, 2-cycle read latency).
- Accepts a burst command (base address, length) and drives the memory read address once per cycle.
- Tracks in-flight reads and re-times returned data into a valid/ready stream with a last-beat flag.
- Credit-based issue: no read is launched unless buffer space for its data is guaranteed, so backpressure never drops data.

Parameters:
DATAW, 8, memory word width
DEPTH, 512, memory depth in words
ADDRW, $clog2(DEPTH), address width
LENW, ADDRW+1, burst length width (0..DEPTH)
RD_LATENCY, 2, cycles from raddr presented to rdata valid at memory output
OBUF_DEPTH, 4, output buffer entries; must be >= RD_LATENCY+1

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, asynchronous, active-low
cmd_valid  in  1  burst command valid
cmd_ready  out  1  block idle, command accepted when cmd_valid&cmd_ready
cmd_base  in  ADDRW  first read address
cmd_len  in  LENW  number of words to read
mem_raddr  out  ADDRW  read address to memory block
mem_rdata  in  DATAW  read data from memory block
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts beat
out_data  out  DATAW  read word (head of output buffer)
out_last  out  1  final beat of burst, qualified by out_valid
busy  out  1  burst in progress
done  out  1  one-cycle pulse at burst completion

Behaviour:
- Reset (rst=0, async): state IDLE; cmd_ready=1; mem_raddr=0; out_valid=0; out_data=0; out_last=0; busy=0; done=0; buffer empty; in-flight pipeline cleared; counters 0.
- States: IDLE, ISSUE, DRAIN.
- IDLE: cmd_ready=1.
  - On accept with cmd_len>0: latch base and len; mem_raddr<=cmd_base; go ISSUE.
  - On accept with cmd_len=0: stay IDLE; done=1 the next cycle; no beats emitted.
- ISSUE: cmd_ready=0, busy=1.
  - A read is issued in a cycle when (occupancy + in_flight) < OBUF_DEPTH. The same-cycle pop is not counted as a credit.
  - On issue: mem_raddr advances by 1 modulo DEPTH (DEPTH-1 -> 0) at the edge, and remaining decrements.
  - When not issuing, mem_raddr holds.
  - After the final issue, go DRAIN.
- In-flight tracking: a RD_LATENCY-deep valid shift register records issue strobes, with the final-issue flag carried alongside. When the strobe exits, mem_rdata is written into the output buffer with its last flag.
- Output buffer: OBUF_DEPTH-entry peek FIFO.
  - out_valid = !empty; out_data/out_last = head entry.
  - Pop on out_valid&out_ready.
  - Simultaneous push and pop keeps occupancy unchanged.
  - Overflow is impossible by credit rule; an overflow indicates a design bug and is asserted in simulation.
- DRAIN: wait until in-flight=0 and the last beat is popped. Then done=1 for one cycle, busy=0, go IDLE.
  - cmd_ready rises in the same cycle as the done pulse.
- Latency: accept edge E0 -> first out_valid visible after edge E3. With out_ready=1, one beat per cycle sustained.
- out_data/out_last are don't-care when out_valid=0. A bench must only compare when out_valid=1.
- Reset mid-burst: all in-flight reads and buffered data are discarded; returns to the IDLE reset values. Memory returning data after reset release is ignored, since the shift register is cleared.
- cmd_* is ignored outside IDLE.

Test Plan:
- Memory preloaded mem[i]=i; cmd base=10 len=4, out_ready=1 -> mem_raddr 10,11,12,13 on consecutive cycles; out_data 10,11,12,13 on consecutive cycles starting after E3; out_last only on 13; done pulse one cycle after that beat; cmd_ready=1 with done.
- Backpressure: base=0 len=8, out_ready=0 -> exactly 4 issues (raddr 0..3) then mem_raddr holds at 4, out_valid=1 with out_data=0. Release out_ready -> all 8 words 0..7 in order, none lost or duplicated.
- Wrap: base=510 len=4 (DEPTH=512) -> raddr 510,511,0,1; data 510&0xFF, 511&0xFF, 0, 1; out_last on 4th beat.
- Zero length: cmd len=0 -> out_valid never asserts; done=1 exactly one cycle after the accept edge; busy stays 0.
- Random out_ready toggle (50%), len=DEPTH base=0 -> 512 beats in address order, single out_last, in_flight+occupancy never exceeds 4.
- Async reset asserted mid-burst (after 2 beats popped), between clock edges -> outputs reach reset values immediately. After release, new cmd base=100 len=2 returns only 100,101.
